ahb5_sram_responder: RTL and testbench
======================================

// Module: ahb5_sram_responder
// PURPOSE
// AHB5 subordinate (responder) that terminates the hazard3_cpu_1port AHB5 manager port in sim and small SoCs.
// Backs a word-addressed SRAM with configurable wait states and byte-lane writes.
// Raises ERROR responses for illegal accesses.
// Contains a single-entry exclusive monitor that drives hexokay for A-extension LR/SC traffic.
// PARAMETERS
// W_ADDR       32  address width
// W_DATA       32  data width (fixed 32; hsize>2 is illegal)
// DEPTH_WORDS  4096  SRAM words; byte address range [0, 4*DEPTH_WORDS)
// WAIT_STATES  0   extra data-phase cycles (hreadyout=0) before completion, 0..15
// PORTS
// clk        in   1       clock
// rst        in   1       synchronous reset, active-high
// hsel       in   1       subordinate select
// haddr      in   W_ADDR  address-phase address
// hwrite     in   1       1=write
// htrans     in   2       IDLE=0 BUSY=1 NONSEQ=2 SEQ=3
// hsize      in   3       0=byte 1=half 2=word
// hexcl      in   1       exclusive transfer
// hmaster    in   8       manager ID, used for exclusive tagging
// hready     in   1       bus-level ready (previous data phase complete)
// hwdata     in   W_DATA  write data, data phase
// hreadyout  out  1       this subordinate's data-phase ready
// hresp      out  1       0=OKAY 1=ERROR
// hexokay    out  1       exclusive success, valid when hreadyout=1
// hrdata     out  W_DATA  read data, valid when hreadyout=1 and read
// BEHAVIOUR
// - Reset (rst=1 at a clk edge): hreadyout=1, hresp=0, hexokay=0, hrdata=0.
//   Reset also sets reservation invalid, state=IDLE, and abandons any pending data phase with no SRAM write.
// - Accept: address phase is taken when hsel & hready & htrans[1].
//   Latch addr, write, size, excl, master.
//   IDLE/BUSY or hsel=0 with hready: zero-wait OKAY, no side effects.
// - Illegal access: hsize>2, haddr misaligned to hsize, or haddr>=4*DEPTH_WORDS.
//   Response is two-cycle ERROR: ERR1 (hreadyout=0, hresp=1), then ERR2 (hreadyout=1, hresp=1).
//   No write; reservation unchanged.
// - States: IDLE, WAIT, DATA, ERR1, ERR2.
//   - Legal accept: to WAIT with cnt=WAIT_STATES-1 if WAIT_STATES>0, else to DATA.
//   - WAIT: hreadyout=0; cnt decrements; to DATA at cnt=0.
//   - DATA: hreadyout=1, completion cycle. A new accept in the same cycle re-enters WAIT/DATA/ERR1; otherwise to IDLE.
// - Latency: with WAIT_STATES=N, data phase is N+1 cycles; back-to-back NONSEQ sustain 1 transfer/(N+1) cycles.
// - Read: SRAM read is issued at the address-phase edge; the word is held in a register.
//   hrdata is the full word (lanes are not zeroed) and is driven while hreadyout=1 for a read; 0 otherwise.
// - Write: byte lanes are selected from size and addr[1:0]; the SRAM is written at the DATA-cycle edge using hwdata.
// - Forwarding: a read accepted on the same edge as a write completing to the same word returns the merged word.
//   The written lanes come from hwdata; the other lanes are the old data.
// - Exclusive monitor: reservation = {valid, word addr, master}.
//   - Exclusive read: sets the reservation; hexokay=1 at completion.
//   - Exclusive write succeeds when valid & addr & master all match: the write is performed, hexokay=1.
//   - Failed exclusive write: no write, hexokay=0, hresp=0.
//   - Any exclusive write clears the reservation.
//   - A non-exclusive write to the reserved word clears it at its completion.
//   - hexokay is always 0 for non-exclusive transfers and for ERROR.
// - A non-exclusive write and an exclusive read of the same word completing back-to-back: the write clears first, then the read sets.
// STRUCTURE
// - Package ahb5_pkg: htrans_t and hsize_t enums.
// - Package ahb5_pkg: responder state_t enum {IDLE,WAIT,DATA,ERR1,ERR2}.
// - Package ahb5_pkg: function for lane mask derived from size/addr[1:0].
// - Sub-module ahb5_excl_monitor: reservation register plus match/set/clear logic, outputs excl_ok.
// - SRAM is an inferred array in this module.
// TESTING
// 1. N=0: write word 0xDEADBEEF @0x10, then read @0x10 -> hrdata=0xDEADBEEF, 1-cycle data phases, hresp=0.
// 2. N=3: read @0x0 -> hreadyout low for exactly 3 cycles, then 1; back-to-back reads each take 4 cycles.
// 3. Byte write 0xAA @0x13 over 0x11223344, then read @0x10 -> 0xAA223344.
//    Same sequence back-to-back at N=0 -> forwarded 0xAA223344.
// 4. haddr=0x2 hsize=2, and haddr=4*DEPTH_WORDS -> ERR1 then ERR2 with hresp=1; SRAM unchanged.
// 5. LR @0x20 (hmaster=1), SC @0x20 (hmaster=1) -> hexokay=1 both, written.
//    Repeat SC -> hexokay=0, not written.
//    LR, plain write @0x20, SC -> SC fails.
// 6. Assert rst during WAIT of a write -> next cycle hreadyout=1, hresp=0, SRAM word unchanged, reservation invalid.

Source files
------------

// File: rtl/ahb5_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ahb5_pkg
// Description : Shared AHB5 encodings, responder state encoding and the
//               byte-lane mask helper for the SRAM responder.
// Revision    : 1.0 - initial release
// ============================================================================
package ahb5_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        DATA = 3'd2,
        ERR1 = 3'd3,
        ERR2 = 3'd4
    } state_t;

    // Only called for legal (aligned, size<=2) transfers.
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] offset);
        logic [3:0] mask;
        case (size)
            HSIZE_BYTE: mask = 4'b0001 << offset;
            HSIZE_HALF: mask = offset[1] ? 4'b1100 : 4'b0011;
            default:    mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb5_excl_monitor.sv
`default_nettype none
// ============================================================================
// Module      : ahb5_excl_monitor
// Description : Single-entry exclusive reservation {valid, word, master}.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb5_excl_monitor
    import ahb5_pkg::*;
#(
    parameter int W_IDX    = 12,
    parameter int W_MASTER = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                complete,
    input  logic                write,
    input  logic                excl,
    input  logic [W_IDX-1:0]    idx,
    input  logic [W_MASTER-1:0] master,
    output logic                excl_ok
);

    logic                valid_q, valid_d;
    logic [W_IDX-1:0]    idx_q, idx_d;
    logic [W_MASTER-1:0] master_q, master_d;
    logic                w_addr_hit;

    always_comb begin
        w_addr_hit = valid_q && (idx_q == idx);
        excl_ok    = w_addr_hit && (master_q == master);
        valid_d    = valid_q;
        idx_d      = idx_q;
        master_d   = master_q;
        if (complete) begin
            // Any exclusive write, or a plain write hitting the reserved word, kills it.
            if (write) begin
                if (excl || w_addr_hit) begin
                    valid_d = 1'b0;
                end
            end else if (excl) begin
                valid_d  = 1'b1;
                idx_d    = idx;
                master_d = master;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            idx_q    <= '0;
            master_q <= '0;
        end else begin
            valid_q  <= valid_d;
            idx_q    <= idx_d;
            master_q <= master_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ahb5_sram_responder.sv
`default_nettype none
// ============================================================================
// Module      : ahb5_sram_responder
// Description : AHB5 SRAM subordinate with wait states, byte lanes, ERROR
//               responses and an exclusive monitor driving hexokay.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb5_sram_responder
    import ahb5_pkg::*;
#(
    parameter int W_ADDR      = 32,
    parameter int W_DATA      = 32,
    parameter int DEPTH_WORDS = 4096,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hsel,
    input  logic [W_ADDR-1:0] haddr,
    input  logic              hwrite,
    input  logic [1:0]        htrans,
    input  logic [2:0]        hsize,
    input  logic              hexcl,
    input  logic [7:0]        hmaster,
    input  logic              hready,
    input  logic [W_DATA-1:0] hwdata,
    output logic              hreadyout,
    output logic              hresp,
    output logic              hexokay,
    output logic [W_DATA-1:0] hrdata
);

    localparam int              c_idx_w      = $clog2(DEPTH_WORDS);
    localparam logic [W_ADDR:0] c_addr_limit = (W_ADDR + 1)'(4 * DEPTH_WORDS);

    logic [W_DATA-1:0] mem [DEPTH_WORDS];

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [c_idx_w-1:0] idx_q, idx_d;
    logic [1:0]         offs_q, offs_d;
    logic [2:0]         size_q, size_d;
    logic               write_q, write_d;
    logic               excl_q, excl_d;
    logic [7:0]         master_q, master_d;
    logic [W_DATA-1:0]  rdata_q, rdata_d;

    logic               w_accept;
    logic               w_illegal;
    logic [c_idx_w-1:0] w_acc_idx;
    logic               w_wr_fire;
    logic [3:0]         w_wr_mask;
    logic               w_excl_ok;
    logic [W_DATA-1:0]  w_rd_word;

    always_comb begin
        w_accept  = hsel && hready && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
        w_illegal = (hsize > 3'd2)
                 || (hsize == HSIZE_HALF && haddr[0])
                 || (hsize == HSIZE_WORD && haddr[1:0] != 2'b00)
                 || ({1'b0, haddr} >= c_addr_limit);
        w_acc_idx = haddr[c_idx_w+1:2];
        w_wr_fire = (state_q == DATA) && write_q && (!excl_q || w_excl_ok);
        w_wr_mask = lane_mask(size_q, offs_q);
        // A write completing this edge to the same word must be visible to the new read.
        w_rd_word = mem[w_acc_idx];
        for (int b = 0; b < 4; b++) begin
            if (w_wr_fire && idx_q == w_acc_idx && w_wr_mask[b]) begin
                w_rd_word[8*b +: 8] = hwdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        offs_d   = offs_q;
        size_d   = size_q;
        write_d  = write_q;
        excl_d   = excl_q;
        master_d = master_q;
        rdata_d  = rdata_q;
        case (state_q)
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ERR1: state_d = ERR2;
            default: begin
                if (w_accept) begin
                    idx_d    = w_acc_idx;
                    offs_d   = haddr[1:0];
                    size_d   = hsize;
                    write_d  = hwrite;
                    excl_d   = hexcl;
                    master_d = hmaster;
                    if (w_illegal) begin
                        state_d = ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_STATES - 1);
                    end else begin
                        state_d = DATA;
                    end
                    if (!hwrite && !w_illegal) begin
                        rdata_d = w_rd_word;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            offs_q   <= '0;
            size_q   <= '0;
            write_q  <= 1'b0;
            excl_q   <= 1'b0;
            master_q <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            offs_q   <= offs_d;
            size_q   <= size_d;
            write_q  <= write_d;
            excl_q   <= excl_d;
            master_q <= master_d;
            rdata_q  <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_wr_fire) begin
            for (int b = 0; b < 4; b++) begin
                if (w_wr_mask[b]) begin
                    mem[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
                end
            end
        end
    end

    ahb5_excl_monitor #(
        .W_IDX    (c_idx_w),
        .W_MASTER (8)
    ) u_excl_monitor (
        .clk      (clk),
        .rst      (rst),
        .complete (state_q == DATA),
        .write    (write_q),
        .excl     (excl_q),
        .idx      (idx_q),
        .master   (master_q),
        .excl_ok  (w_excl_ok)
    );

    assign hreadyout = !(state_q == WAIT || state_q == ERR1);
    assign hresp     = (state_q == ERR1) || (state_q == ERR2);
    assign hexokay   = (state_q == DATA) && excl_q && (!write_q || w_excl_ok);
    assign hrdata    = (state_q == DATA && !write_q) ? rdata_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_ahb5_sram_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb5_sram_responder
// Description : Scoreboard bench for ahb5_sram_responder at 0 and 3 wait states.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb5_sram_responder;

    localparam int DEPTH = 64;

    typedef struct {
        logic        active;
        logic        write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic        excl;
        logic [7:0]  master;
        logic [31:0] wdata;
        string       tag;
    } xfer_t;

    typedef struct {
        logic [31:0] rdata;
        logic        resp;
        logic        exok;
        int          waits;
        logic [31:0] wdata;
        string       tag;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] haddr;
    logic        hwrite;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic        hexcl;
    logic [7:0]  hmaster;
    logic [31:0] hwdata;
    logic        hsel0, hsel1;
    logic        hreadyout0, hresp0, hexokay0;
    logic        hreadyout1, hresp1, hexokay1;
    logic [31:0] hrdata0, hrdata1;

    ahb5_sram_responder #(
        .W_ADDR(32), .W_DATA(32), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0)
    ) u_dut0 (
        .clk(clk), .rst(rst), .hsel(hsel0), .haddr(haddr), .hwrite(hwrite),
        .htrans(htrans), .hsize(hsize), .hexcl(hexcl), .hmaster(hmaster),
        .hready(hreadyout0), .hwdata(hwdata), .hreadyout(hreadyout0),
        .hresp(hresp0), .hexokay(hexokay0), .hrdata(hrdata0)
    );

    ahb5_sram_responder #(
        .W_ADDR(32), .W_DATA(32), .DEPTH_WORDS(DEPTH), .WAIT_STATES(3)
    ) u_dut1 (
        .clk(clk), .rst(rst), .hsel(hsel1), .haddr(haddr), .hwrite(hwrite),
        .htrans(htrans), .hsize(hsize), .hexcl(hexcl), .hmaster(hmaster),
        .hready(hreadyout1), .hwdata(hwdata), .hreadyout(hreadyout1),
        .hresp(hresp1), .hexokay(hexokay1), .hrdata(hrdata1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    xfer_t stim_q[$];
    exp_t  sb_q[$];

    logic [31:0] mdl_mem [2][DEPTH];
    logic        rv [2];
    int          ra [2];
    logic [7:0]  rm [2];

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Reference behaviour in program order: memory, lanes and reservation.
    function automatic exp_t model(input int inst, input xfer_t x);
        exp_t e;
        int   idx, off, bytes;
        logic bad, ok;
        e.tag   = x.tag;
        e.wdata = x.wdata;
        e.rdata = 32'h0;
        e.resp  = 1'b0;
        e.exok  = 1'b0;
        e.waits = (inst == 0) ? 0 : 3;
        bad = (x.size > 3'd2) || (x.size == 3'd1 && x.addr[0])
           || (x.size == 3'd2 && x.addr[1:0] != 2'b00) || (x.addr >= 32'(4 * DEPTH));
        if (bad) begin
            e.resp  = 1'b1;
            e.waits = 1;
            return e;
        end
        idx = int'(x.addr >> 2);
        if (x.write) begin
            ok = !x.excl || (rv[inst] && ra[inst] == idx && rm[inst] == x.master);
            if (ok) begin
                off   = int'(x.addr[1:0]);
                bytes = 1 << x.size;
                for (int b = 0; b < 4; b++) begin
                    if (b >= off && b < off + bytes) mdl_mem[inst][idx][8*b +: 8] = x.wdata[8*b +: 8];
                end
            end
            if (x.excl || (rv[inst] && ra[inst] == idx)) rv[inst] = 1'b0;
            e.exok = x.excl && ok;
        end else begin
            e.rdata = mdl_mem[inst][idx];
            if (x.excl) begin
                rv[inst] = 1'b1;
                ra[inst] = idx;
                rm[inst] = x.master;
            end
            e.exok = x.excl;
        end
        return e;
    endfunction

    task automatic put(input logic wr, input logic [31:0] a, input logic [2:0] sz, input logic ex,
                       input logic [7:0] m, input logic [31:0] wd, input string tag);
        xfer_t x;
        x.active = 1'b1; x.write = wr; x.addr = a; x.size = sz;
        x.excl = ex; x.master = m; x.wdata = wd; x.tag = tag;
        stim_q.push_back(x);
    endtask

    task automatic gap();
        xfer_t x;
        x.active = 1'b0; x.write = 1'b0; x.addr = 32'h0; x.size = 3'd0;
        x.excl = 1'b0; x.master = 8'h0; x.wdata = 32'h0; x.tag = "gap";
        stim_q.push_back(x);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] wd, input string tag);
        put(1'b1, a, 3'd2, 1'b0, 8'd0, wd, tag);
    endtask

    task automatic rd(input logic [31:0] a, input string tag);
        put(1'b0, a, 3'd2, 1'b0, 8'd0, 32'h0, tag);
    endtask

    task automatic drive(input int inst, input xfer_t x);
        hsel0   = (inst == 0);
        hsel1   = (inst == 1);
        htrans  = x.active ? 2'b10 : 2'b00;
        haddr   = x.addr;
        hwrite  = x.write;
        hsize   = x.size;
        hexcl   = x.excl;
        hmaster = x.master;
    endtask

    task automatic drive_idle();
        hsel0  = 1'b0;
        hsel1  = 1'b0;
        htrans = 2'b00;
        hexcl  = 1'b0;
    endtask

    task automatic run_queue(input int inst);
        int    wcnt, guard;
        logic  rdy;
        xfer_t x;
        exp_t  e;
        wcnt  = 0;
        guard = 0;
        while ((stim_q.size() > 0 || sb_q.size() > 0) && guard < 500) begin
            @(negedge clk);
            guard++;
            rdy = (inst == 0) ? hreadyout0 : hreadyout1;
            if (sb_q.size() > 0) begin
                e      = sb_q[0];
                hwdata = e.wdata;
                if (rdy) begin
                    chk_val({e.tag, "_rdata"}, (inst == 0) ? hrdata0 : hrdata1, e.rdata);
                    chk_val({e.tag, "_hresp"}, 32'((inst == 0) ? hresp0 : hresp1), 32'(e.resp));
                    chk_val({e.tag, "_hexokay"}, 32'((inst == 0) ? hexokay0 : hexokay1), 32'(e.exok));
                    chk_val({e.tag, "_stall_cycles"}, 32'(wcnt), 32'(e.waits));
                    void'(sb_q.pop_front());
                    wcnt = 0;
                end else begin
                    wcnt++;
                    chk_val({e.tag, "_stall_hresp"}, 32'((inst == 0) ? hresp0 : hresp1), 32'(e.resp));
                end
            end
            if (rdy) begin
                if (stim_q.size() > 0) begin
                    x = stim_q.pop_front();
                    drive(inst, x);
                    if (x.active) sb_q.push_back(model(inst, x));
                end else begin
                    drive_idle();
                end
            end
        end
        chk_val("run_queue_drained", 32'(stim_q.size() + sb_q.size()), 32'h0);
        stim_q.delete();
        sb_q.delete();
    endtask

    initial begin
        rst = 1'b1;
        hsel0 = 1'b0; hsel1 = 1'b0; htrans = 2'b00; haddr = 32'h0; hwrite = 1'b0;
        hsize = 3'd0; hexcl = 1'b0; hmaster = 8'h0; hwdata = 32'h0;
        for (int i = 0; i < 2; i++) begin
            rv[i] = 1'b0; ra[i] = 0; rm[i] = 8'h0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_val("reset_hreadyout", 32'(hreadyout0), 32'h1);
        chk_val("reset_hresp", 32'(hresp0), 32'h0);
        chk_val("reset_hexokay", 32'(hexokay0), 32'h0);
        chk_val("reset_hrdata", hrdata0, 32'h0);
        chk_val("reset_hreadyout_n3", 32'(hreadyout1), 32'h1);
        rst = 1'b0;

        // Zero wait states: basic, lanes, forwarding, errors, exclusives.
        wr(32'h10, 32'hDEADBEEF, "t1_wr"); gap(); rd(32'h10, "t1_rd"); gap();
        wr(32'h10, 32'h11223344, "t3_wr"); gap();
        put(1'b1, 32'h13, 3'd0, 1'b0, 8'd0, 32'hAA5A5A5A, "t3_wrb"); gap();
        rd(32'h10, "t3_rd"); gap();
        wr(32'h14, 32'h11223344, "t3f_wr");
        put(1'b1, 32'h17, 3'd0, 1'b0, 8'd0, 32'hAA5A5A5A, "t3f_wrb");
        rd(32'h14, "t3f_rd");
        wr(32'h18, 32'h0, "t3h_wr");
        put(1'b1, 32'h1A, 3'd1, 1'b0, 8'd0, 32'hCAFE1234, "t3h_wrh");
        rd(32'h18, "t3h_rd");
        wr(32'h0, 32'h01020304, "t4_wr");
        put(1'b1, 32'h2, 3'd2, 1'b0, 8'd0, 32'hFFFFFFFF, "t4_misalign");
        put(1'b1, 32'(4 * DEPTH), 3'd2, 1'b0, 8'd0, 32'hFFFFFFFF, "t4_range");
        put(1'b0, 32'h1, 3'd1, 1'b0, 8'd0, 32'h0, "t4_half_mis");
        put(1'b1, 32'h0, 3'd3, 1'b0, 8'd0, 32'hFFFFFFFF, "t4_size");
        rd(32'h0, "t4_rd");
        wr(32'h20, 32'h0, "t5_init");
        put(1'b0, 32'h20, 3'd2, 1'b1, 8'd1, 32'h0, "t5_lr");
        put(1'b1, 32'h20, 3'd2, 1'b1, 8'd1, 32'h12345678, "t5_sc");
        rd(32'h20, "t5_rd1");
        put(1'b1, 32'h20, 3'd2, 1'b1, 8'd1, 32'h99999999, "t5_sc2");
        rd(32'h20, "t5_rd2");
        put(1'b0, 32'h20, 3'd2, 1'b1, 8'd1, 32'h0, "t5_lr3");
        wr(32'h20, 32'h00000055, "t5_plain");
        put(1'b1, 32'h20, 3'd2, 1'b1, 8'd1, 32'hEEEEEEEE, "t5_sc3");
        rd(32'h20, "t5_rd3");
        put(1'b0, 32'h20, 3'd2, 1'b1, 8'd1, 32'h0, "t5_lr4");
        put(1'b1, 32'h20, 3'd2, 1'b1, 8'd2, 32'h77777777, "t5_sc_other");
        rd(32'h20, "t5_rd4");
        wr(32'h20, 32'h0, "t5_wr_then_lr");
        put(1'b0, 32'h20, 3'd2, 1'b1, 8'd1, 32'h0, "t5_lr5");
        put(1'b1, 32'h20, 3'd2, 1'b1, 8'd1, 32'h31415926, "t5_sc5");
        rd(32'h20, "t5_rd5");
        run_queue(0);

        // Three wait states: latency, back-to-back reads, error, then reset mid-write.
        wr(32'h0, 32'hA5A5A5A5, "n3_wr");
        rd(32'h0, "n3_rd_a"); rd(32'h0, "n3_rd_b"); rd(32'h0, "n3_rd_c");
        wr(32'h30, 32'h00000077, "n3_wr30");
        put(1'b0, 32'h30, 3'd2, 1'b1, 8'd1, 32'h0, "n3_lr");
        put(1'b0, 32'h2, 3'd2, 1'b0, 8'd0, 32'h0, "n3_err");
        run_queue(1);

        @(negedge clk);
        chk_val("rst_pre_ready", 32'(hreadyout1), 32'h1);
        hsel1 = 1'b1; htrans = 2'b10; haddr = 32'h0; hwrite = 1'b1; hsize = 3'd2; hexcl = 1'b0;
        @(negedge clk);
        chk_val("rst_in_wait", 32'(hreadyout1), 32'h0);
        hsel1 = 1'b0; htrans = 2'b00; hwdata = 32'h0BADF00D; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_val("rst_mid_hreadyout", 32'(hreadyout1), 32'h1);
        chk_val("rst_mid_hresp", 32'(hresp1), 32'h0);
        chk_val("rst_mid_hexokay", 32'(hexokay1), 32'h0);
        chk_val("rst_mid_hrdata", hrdata1, 32'h0);
        rv[0] = 1'b0;
        rv[1] = 1'b0;
        put(1'b1, 32'h30, 3'd2, 1'b1, 8'd1, 32'hDEAD0000, "n3_sc_after_rst");
        rd(32'h0, "n3_rd_after_rst");
        rd(32'h30, "n3_rd30_after_rst");
        run_queue(1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
